// File: rtl/dmac_ahb_slave.sv
// dmac_ahb_slave
//   AHB-Lite word-only memory slave with a configurable number of wait
//   states per accepted transfer and a two-cycle ERROR response.
//
// Parameters
//   DEPTH       number of 32-bit words (power of two, 2..256)
//   WAIT_STATES HREADYOUT-low cycles per accepted legal transfer (0..15)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   HSEL       slave select
//   HADDR      byte address (address phase)
//   HTRANS     00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//   HWRITE     1 write, 0 read
//   HSIZE      transfer size, only 3'b010 is legal
//   HWDATA     write data (data phase)
//   HREADY     bus-level ready
//   HRDATA     read data, 0 outside a read data phase
//   HREADYOUT  this slave's ready
//   HResp      00 OKAY, 01 ERROR
module dmac_ahb_slave #(
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic [1:0]  HResp
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [3:0]  WS_LOAD    = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [AW-1:0]          idx_q, idx_d;
  logic                   wr_q, wr_d;
  logic [DEPTH-1:0][31:0] mem_q;

  logic accept;
  logic req_err;

  // Address phases are only looked at while this slave is ready (IDLE,
  // DATA, ERR2); in WAIT and ERR1 the registered transfer is authoritative.
  assign accept  = HSEL && HREADY && HTRANS[1] &&
                   (state_q != S_WAIT) && (state_q != S_ERR1);
  assign req_err = (HSIZE != 3'b010) || (HADDR[1:0] != 2'b00) ||
                   (HADDR >= ADDR_LIMIT);

  // State register and registered address phase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    case (state_q)
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_DATA;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ERR1: state_d = S_ERR2;
      // IDLE, DATA, ERR2 and any illegal encoding: a transfer may start here
      default: begin
        state_d = S_IDLE;
        if (accept) begin
          idx_d = HADDR[AW+1:2];
          wr_d  = HWRITE;
          if (req_err) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WS_LOAD;
          end else begin
            state_d = S_DATA;
          end
        end
      end
    endcase
  end

  // Outputs
  always_comb begin
    HREADYOUT = 1'b1;
    HResp     = 2'b00;
    HRDATA    = 32'd0;
    case (state_q)
      S_WAIT: HREADYOUT = 1'b0;
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HResp     = 2'b01;
      end
      S_ERR2: HResp = 2'b01;
      S_DATA: if (!wr_q) HRDATA = mem_q[idx_q];
      default: ;
    endcase
  end

  // Storage: DATA always lasts one cycle, so the write lands on the edge
  // that ends it and a read whose data phase follows sees the new value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '0;
    end else if (state_q == S_DATA && wr_q) begin
      mem_q[idx_q] <= HWDATA;
    end
  end

endmodule

// File: tb/tb_dmac_ahb_slave.sv
module tb_dmac_ahb_slave;

  localparam logic [1:0] IDL = 2'b00, BSY = 2'b01, NSQ = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] W   = 3'b010;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel1, sel0;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic [31:0] rd1, rd0;
  logic        rdy1, rdy0;
  logic [1:0]  resp1, resp0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmac_ahb_slave #(.DEPTH(16), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst(rst), .HSEL(sel1), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(rdy1),
    .HRDATA(rd1), .HREADYOUT(rdy1), .HResp(resp1)
  );

  dmac_ahb_slave #(.DEPTH(16), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .HSEL(sel0), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(rdy0),
    .HRDATA(rd0), .HREADYOUT(rdy0), .HResp(resp0)
  );

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic        e_rdy;
    logic [1:0]  e_resp;
    logic [31:0] e_rd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic s, input logic [1:0] tr, input logic wr,
                             input logic [31:0] a, input logic [2:0] sz,
                             input logic [31:0] wd, input logic er,
                             input logic [1:0] ep, input logic [31:0] ed);
    vec_t r;
    r.sel = s; r.trans = tr; r.wr = wr; r.addr = a; r.size = sz; r.wdata = wd;
    r.e_rdy = er; r.e_resp = ep; r.e_rd = ed;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic s1, input logic s0, input logic [1:0] tr,
                     input logic wr, input logic [31:0] a, input logic [2:0] sz,
                     input logic [31:0] wd);
    sel1 = s1; sel0 = s0; HTRANS = tr; HWRITE = wr; HADDR = a; HSIZE = sz; HWDATA = wd;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] bd[4];
    logic [31:0] ra[4];
    bd = '{32'h1000_0001, 32'h2000_0002, 32'h3000_0003, 32'h4000_0004};
    ra = '{32'hC, 32'h0, 32'h4, 32'h8};

    // one row per clock: inputs for the cycle, outputs expected in it
    tbl.push_back(v(0, IDL, 0, 32'h00, W, 32'h0,          1, 0, 32'h0));
    // single write 0x08 then read back
    tbl.push_back(v(1, NSQ, 1, 32'h08, W, 32'h0,          1, 0, 32'h0));
    tbl.push_back(v(1, IDL, 0, 32'h00, W, 32'hDEADBEEF,   0, 0, 32'h0));
    tbl.push_back(v(1, IDL, 0, 32'h00, W, 32'hDEADBEEF,   1, 0, 32'h0));
    tbl.push_back(v(1, NSQ, 0, 32'h08, W, 32'h0,          1, 0, 32'h0));
    tbl.push_back(v(1, IDL, 0, 32'h00, W, 32'h0,          0, 0, 32'h0));
    tbl.push_back(v(1, IDL, 0, 32'h00, W, 32'h0,          1, 0, 32'hDEADBEEF));
    // out-of-range read 0x40
    tbl.push_back(v(1, NSQ, 0, 32'h40, W, 32'h0,          1, 0, 32'h0));
    tbl.push_back(v(1, IDL, 0, 32'h00, W, 32'h0,          0, 1, 32'h0));
    tbl.push_back(v(1, IDL, 0, 32'h00, W, 32'h0,          1, 1, 32'h0));
    tbl.push_back(v(1, IDL, 0, 32'h00, W, 32'h0,          1, 0, 32'h0));
    // write 0x4, pipelined byte-size write to 0x4 (error), pipelined read from ERR2
    tbl.push_back(v(1, NSQ, 1, 32'h04, W, 32'h0,          1, 0, 32'h0));
    tbl.push_back(v(1, IDL, 0, 32'h00, W, 32'h11111111,   0, 0, 32'h0));
    tbl.push_back(v(1, NSQ, 1, 32'h04, 3'b000, 32'h11111111, 1, 0, 32'h0));
    tbl.push_back(v(1, IDL, 0, 32'h00, W, 32'h22222222,   0, 1, 32'h0));
    tbl.push_back(v(1, NSQ, 0, 32'h04, W, 32'h22222222,   1, 1, 32'h0));
    tbl.push_back(v(1, IDL, 0, 32'h00, W, 32'h0,          0, 0, 32'h0));
    tbl.push_back(v(1, IDL, 0, 32'h00, W, 32'h0,          1, 0, 32'h11111111));
    // NONSEQ, BUSY, SEQ burst; BUSY data phase carries junk that must not land
    tbl.push_back(v(1, NSQ, 1, 32'h0C, W, 32'h0,          1, 0, 32'h0));
    tbl.push_back(v(1, BSY, 1, 32'h14, W, 32'hAAAA0001,   0, 0, 32'h0));
    tbl.push_back(v(1, BSY, 1, 32'h14, W, 32'hAAAA0001,   1, 0, 32'h0));
    tbl.push_back(v(1, SEQ, 1, 32'h10, W, 32'hBAD0BAD0,   1, 0, 32'h0));
    tbl.push_back(v(1, IDL, 0, 32'h00, W, 32'hAAAA0002,   0, 0, 32'h0));
    tbl.push_back(v(1, NSQ, 0, 32'h0C, W, 32'hAAAA0002,   1, 0, 32'h0));
    tbl.push_back(v(1, IDL, 0, 32'h00, W, 32'h0,          0, 0, 32'h0));
    tbl.push_back(v(1, SEQ, 0, 32'h10, W, 32'h0,          1, 0, 32'hAAAA0001));
    tbl.push_back(v(1, IDL, 0, 32'h00, W, 32'h0,          0, 0, 32'h0));
    tbl.push_back(v(1, NSQ, 0, 32'h14, W, 32'h0,          1, 0, 32'hAAAA0002));
    tbl.push_back(v(1, IDL, 0, 32'h00, W, 32'h0,          0, 0, 32'h0));
    tbl.push_back(v(1, IDL, 0, 32'h00, W, 32'h0,          1, 0, 32'h0));
    // misaligned write 0x2, then word 0 must still read 0
    tbl.push_back(v(1, NSQ, 1, 32'h02, W, 32'h0,          1, 0, 32'h0));
    tbl.push_back(v(1, IDL, 0, 32'h00, W, 32'h77777777,   0, 1, 32'h0));
    tbl.push_back(v(1, IDL, 0, 32'h00, W, 32'h77777777,   1, 1, 32'h0));
    tbl.push_back(v(1, NSQ, 0, 32'h00, W, 32'h0,          1, 0, 32'h0));
    tbl.push_back(v(1, IDL, 0, 32'h00, W, 32'h0,          0, 0, 32'h0));
    // last legal word 0x3C
    tbl.push_back(v(1, NSQ, 1, 32'h3C, W, 32'h0,          1, 0, 32'h0));
    tbl.push_back(v(1, IDL, 0, 32'h00, W, 32'h5A5A5A5A,   0, 0, 32'h0));
    tbl.push_back(v(1, NSQ, 0, 32'h3C, W, 32'h5A5A5A5A,   1, 0, 32'h0));
    tbl.push_back(v(1, IDL, 0, 32'h00, W, 32'h0,          0, 0, 32'h0));
    tbl.push_back(v(1, IDL, 0, 32'h00, W, 32'h0,          1, 0, 32'h5A5A5A5A));
    // unselected NONSEQ write is no transfer
    tbl.push_back(v(0, NSQ, 1, 32'h00, W, 32'hFFFFFFFF,   1, 0, 32'h0));
    tbl.push_back(v(1, NSQ, 0, 32'h00, W, 32'hFFFFFFFF,   1, 0, 32'h0));
    tbl.push_back(v(1, IDL, 0, 32'h00, W, 32'h0,          0, 0, 32'h0));
    tbl.push_back(v(1, IDL, 0, 32'h00, W, 32'h0,          1, 0, 32'h0));

    drv(0, 0, IDL, 0, 32'h0, W, 32'h0);
    #2;
    chk("rst ws1 ready", 32'(rdy1), 32'd1);
    chk("rst ws1 resp",  32'(resp1), 32'd0);
    chk("rst ws1 rdata", rd1, 32'd0);
    chk("rst ws0 ready", 32'(rdy0), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;

    // table on the one-wait-state slave
    for (int i = 0; i < tbl.size(); i++) begin
      drv(tbl[i].sel, 1'b0, tbl[i].trans, tbl[i].wr, tbl[i].addr, tbl[i].size, tbl[i].wdata);
      @(negedge clk);
      chk($sformatf("row%0d ready", i), 32'(rdy1), 32'(tbl[i].e_rdy));
      chk($sformatf("row%0d resp", i),  32'(resp1), 32'(tbl[i].e_resp));
      chk($sformatf("row%0d rdata", i), rd1, tbl[i].e_rd);
      next_cyc();
    end

    // zero-wait pipelined burst: 4 writes, then back-to-back reads
    for (int i = 0; i < 4; i++) begin
      drv(1'b0, 1'b1, (i == 0) ? NSQ : SEQ, 1'b1, 32'(4 * i), W, (i == 0) ? 32'h0 : bd[i-1]);
      @(negedge clk);
      chk($sformatf("burst wr%0d ready", i), 32'(rdy0), 32'd1);
      chk($sformatf("burst wr%0d resp", i), 32'(resp0), 32'd0);
      next_cyc();
    end
    drv(1'b0, 1'b1, NSQ, 1'b0, 32'hC, W, bd[3]);
    @(negedge clk);
    chk("burst wr3 ready", 32'(rdy0), 32'd1);
    next_cyc();
    for (int i = 0; i < 4; i++) begin
      drv(1'b0, 1'b1, (i < 3) ? SEQ : IDL, 1'b0, (i < 3) ? ra[i+1] : 32'h0, W, 32'h0);
      @(negedge clk);
      chk($sformatf("burst rd%0d ready", i), 32'(rdy0), 32'd1);
      chk($sformatf("burst rd%0d data", i), rd0, bd[ra[i][3:2]]);
      next_cyc();
    end
    drv(1'b0, 1'b0, IDL, 1'b0, 32'h0, W, 32'h0);
    @(negedge clk);
    chk("burst idle rdata", rd0, 32'd0);
    next_cyc();

    // reset asserted while a write to 0x0 is in WAIT
    drv(1'b1, 1'b0, NSQ, 1'b1, 32'h0, W, 32'h0);
    @(negedge clk);
    chk("rstw accept ready", 32'(rdy1), 32'd1);
    next_cyc();
    drv(1'b1, 1'b0, IDL, 1'b0, 32'h0, W, 32'h12345678);
    @(negedge clk);
    chk("rstw wait ready", 32'(rdy1), 32'd0);
    #1 rst = 1'b0;
    #1;
    chk("rstw async ready", 32'(rdy1), 32'd1);
    chk("rstw async resp", 32'(resp1), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    drv(1'b1, 1'b0, NSQ, 1'b0, 32'h0, W, 32'h12345678);
    @(negedge clk);
    chk("rstw rd ready", 32'(rdy1), 32'd1);
    next_cyc();
    drv(1'b1, 1'b0, IDL, 1'b0, 32'h0, W, 32'h0);
    @(negedge clk);
    chk("rstw rd wait", 32'(rdy1), 32'd0);
    next_cyc();
    @(negedge clk);
    chk("rstw rd ready2", 32'(rdy1), 32'd1);
    chk("rstw mem0", rd1, 32'd0);
    next_cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
